prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer.sv | 111 +++++++++++
 tb/tb_prog_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// Programmable tick timer: counts down count_en ticks and emits a one-cycle expiry pulse, in one-shot or periodic mode.
// Optional sticky expiry flag with clear input when PROG_TIMER_STICKY_EN is defined.
module prog_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load,
  input  logic             count_en,
  input  logic             mode,
  input  logic             pause,
  input  logic             abort,
`ifdef PROG_TIMER_STICKY_EN
  input  logic             clear,
  output logic             expired,
`endif
  output logic             out,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             out_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      out    <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      out    <= out_nxt;
    end
  end

  // Priority abort > load > pause > count_en; a tick coinciding with load is dropped.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    out_nxt    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (load) begin
      if (load_value != '0) begin
        reload_nxt = load_value;
        count_nxt  = load_value;
        state_nxt  = RUN;
      end else begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nxt = HOLD;
          end else if (count_en) begin
            if (count > WIDTH'(1)) begin
              count_nxt = count - WIDTH'(1);
            end else begin
              // Expiry: mode is sampled here, so it may change between periods.
              out_nxt = 1'b1;
              if (mode) begin
                count_nxt = reload;
              end else begin
                count_nxt = '0;
                state_nxt = IDLE;
              end
            end
          end
        end
        HOLD: begin
          if (!pause) state_nxt = RUN;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef PROG_TIMER_STICKY_EN
  // Set wins over clear so a pulse in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired <= 1'b0;
    end else if (out_nxt) begin
      expired <= 1'b1;
    end else if (clear) begin
      expired <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer (WIDTH=7, count_en every 4th cycle).
module tb_prog_timer;
  localparam int WIDTH = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             load = 1'b0;
  logic             count_en = 1'b0;
  logic             mode = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic             out;
  logic             busy;
  logic [WIDTH-1:0] count;
`ifdef PROG_TIMER_STICKY_EN
  logic             clear = 1'b0;
  logic             expired;
`endif

  int n_vec = 0;
  int n_err = 0;
  int npulse = 0;

  prog_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_value (load_value),
    .load       (load),
    .count_en   (count_en),
    .mode       (mode),
    .pause      (pause),
    .abort      (abort),
`ifdef PROG_TIMER_STICKY_EN
    .clear      (clear),
    .expired    (expired),
`endif
    .out        (out),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic en);
    count_en = en;
    @(posedge clk);
    #1;
    count_en = 1'b0;
    npulse += int'(out);
  endtask

  task automatic tick();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_load(input int v, input logic m);
    load_value = WIDTH'(v);
    mode = m;
    load = 1'b1;
    cyc(1'b0);
    load = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out", int'(out), 0);
    #10 reset = 1'b1;
    cyc(1'b0);
    tick();
    check("idle_tick_busy", int'(busy), 0);

    // Periodic 5: count sequence 4,3,2,1,5... and 8 pulses in 40 ticks
    do_load(5, 1'b1);
    check("p5_load_count", int'(count), 5);
    check("p5_load_busy", int'(busy), 1);
    npulse = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check($sformatf("p5_count_t%0d", i), int'(count), (i % 5 == 0) ? 5 : 5 - (i % 5));
      check($sformatf("p5_out_t%0d", i), int'(out), (i % 5 == 0) ? 1 : 0);
    end
    check("p5_pulses", npulse, 8);
    abort = 1'b1; cyc(1'b0); abort = 1'b0;

    // One-shot 3
    do_load(3, 1'b0);
    npulse = 0;
    tick(); tick();
    check("os3_count2", int'(count), 1);
    check("os3_nopulse", npulse, 0);
    tick();
    check("os3_out", int'(out), 1);
    check("os3_count0", int'(count), 0);
    check("os3_busy", int'(busy), 0);
    tick(); tick();
    check("os3_pulses", npulse, 1);

    // One-shot 6 with pause across 3 ticks at count=4
    do_load(6, 1'b0);
    npulse = 0;
    tick(); tick();
    check("ps_count4", int'(count), 4);
    pause = 1'b1;
    tick(); tick(); tick();
    check("ps_hold_count", int'(count), 4);
    check("ps_hold_busy", int'(busy), 1);
    pause = 1'b0;
    tick(); tick(); tick();
    check("ps_count1", int'(count), 1);
    check("ps_nopulse", npulse, 0);
    tick();
    check("ps_out", int'(out), 1);
    check("ps_pulses", npulse, 1);

    // Reload at count=2 with coincident tick, then abort mid-run
    do_load(5, 1'b0);
    npulse = 0;
    tick(); tick(); tick();
    check("rl_count2", int'(count), 2);
    load_value = WIDTH'(2);
    load = 1'b1;
    cyc(1'b1);
    load = 1'b0;
    load_value = WIDTH'(9);
    check("rl_dropped", int'(count), 2);
    tick();
    check("rl_count1", int'(count), 1);
    tick();
    check("rl_out", int'(out), 1);
    check("rl_pulses", npulse, 1);
    do_load(5, 1'b1);
    npulse = 0;
    tick();
    check("ab_count4", int'(count), 4);
    abort = 1'b1; cyc(1'b1); abort = 1'b0;
    check("ab_count", int'(count), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_out", int'(out), 0);
    for (int i = 0; i < 5; i++) tick();
    check("ab_pulses", npulse, 0);

    // Load 0, then load 1 periodic (including back-to-back ticks)
    npulse = 0;
    do_load(0, 1'b1);
    check("z_busy", int'(busy), 0);
    check("z_count", int'(count), 0);
    tick(); tick();
    check("z_pulses", npulse, 0);
    do_load(1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("one_pulses", npulse, 4);
    check("one_count", int'(count), 1);
    npulse = 0;
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check("one_b2b_pulses", npulse, 3);
    cyc(1'b0);
    check("one_b2b_end", int'(out), 0);

`ifdef PROG_TIMER_STICKY_EN
    check("st_set", int'(expired), 1);
    clear = 1'b1; cyc(1'b0); clear = 1'b0;
    check("st_clr", int'(expired), 0);
    clear = 1'b1; cyc(1'b1); clear = 1'b0;
    check("st_set_wins", int'(expired), 1);
`endif

    // Asynchronous reset between edges during RUN
    do_load(5, 1'b1);
    tick();
    check("ar_count4", int'(count), 4);
    #2 reset = 1'b0;
    #1;
    check("ar_count", int'(count), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_out", int'(out), 0);
`ifdef PROG_TIMER_STICKY_EN
    check("ar_expired", int'(expired), 0);
`endif
    #1 reset = 1'b1;
    tick();
    check("ar_after_busy", int'(busy), 0);
    check("ar_after_count", int'(count), 0);
    do_load(2, 1'b0);
    tick(); tick();
    check("ar_reload_out", int'(out), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
